// File: rtl/packet_gen_if.sv
// packet_gen bus bundle: Avalon-MM CSR slave plus Avalon-ST source.
// slave = generator side, master = host/sink side.
interface packet_gen_if;
    logic [2:0]  csr_address_i;
    logic        csr_write_i;
    logic [31:0] csr_writedata_i;
    logic        csr_read_i;
    logic [31:0] csr_readdata_o;
    logic        csr_readdatavalid_o;
    logic        csr_waitrequest_o;
    logic        ast_ready_i;
    logic [63:0] ast_data_o;
    logic        ast_valid_o;
    logic        ast_startofpacket_o;
    logic        ast_endofpacket_o;
    logic [2:0]  ast_empty_o;

    modport slave (
        input  csr_address_i, csr_write_i, csr_writedata_i,
        input  csr_read_i, ast_ready_i,
        output csr_readdata_o, csr_readdatavalid_o,
        output csr_waitrequest_o, ast_data_o, ast_valid_o,
        output ast_startofpacket_o, ast_endofpacket_o, ast_empty_o
    );

    modport master (
        output csr_address_i, csr_write_i, csr_writedata_i,
        output csr_read_i, ast_ready_i,
        input  csr_readdata_o, csr_readdatavalid_o,
        input  csr_waitrequest_o, ast_data_o, ast_valid_o,
        input  ast_startofpacket_o, ast_endofpacket_o, ast_empty_o
    );
endinterface

// File: rtl/packet_gen.sv
// packet_gen: CSR-configured Avalon-ST packet source with pattern insert.
// Optional back-to-back streaming: define PACKET_GEN_CONTINUOUS_EN.
module packet_gen #(
    parameter int unsigned MAX_LEN = 2048,
    parameter logic [15:0] LEN_RST = 16'd64,
    parameter logic [95:0] PATTERN = 96'h21646C726F772C6F6C6C6568
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    packet_gen_if.slave bus
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      r_state;
    logic        r_ins_en;
    logic [15:0] r_len;
    logic [15:0] r_offset;
    logic [7:0]  r_seed;
    logic [31:0] r_pktcnt;
    logic [15:0] r_cfg_len;
    logic [15:0] r_cfg_off;
    logic [7:0]  r_cfg_seed;
    logic        r_cfg_ins;
    logic [15:0] r_word;
    logic [63:0] r_data;
    logic        r_valid;
    logic        r_sop;
    logic        r_eop;
    logic [2:0]  r_empty;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    logic        w_cont;
    logic        w_busy;
    logic        w_wr;
    logic        w_start;
    logic        w_xfer;
    logic        w_last_xfer;
    logic [15:0] w_g_len;
    logic [15:0] w_g_off;
    logic [7:0]  w_g_seed;
    logic        w_g_ins;
    logic [15:0] w_g_word;
    logic [15:0] w_last_word;
    logic [63:0] w_g_data;
    logic        w_g_eop;
    logic [2:0]  w_g_empty;
    logic [31:0] w_rdata;

`ifdef PACKET_GEN_CONTINUOUS_EN
    logic r_cont;
    assign w_cont = r_cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_busy      = (r_state == S_SEND);
    assign w_wr        = bus.csr_write_i;
    assign w_start     = w_wr && (bus.csr_address_i == 3'd0)
                         && bus.csr_writedata_i[0] && !w_busy;
    assign w_xfer      = r_valid && bus.ast_ready_i;
    assign w_last_xfer = w_xfer && r_eop;

    // Packet byte n: zero past the end, pattern inside the window, else ramp
    function automatic logic [7:0] f_byte(
        input logic [18:0] n,
        input logic [15:0] len,
        input logic [15:0] off,
        input logic [7:0]  seed,
        input logic        ins
    );
        logic [18:0] l;
        logic [18:0] o;
        logic [18:0] rel;
        l   = {3'b000, len};
        o   = {3'b000, off};
        rel = n - o;
        if (n >= l) return 8'd0;
        if (ins && (o + 19'd12 <= l) && (n >= o) && (rel < 19'd12))
            return PATTERN[{rel[3:0], 3'b000} +: 8];
        return seed + n[7:0];
    endfunction

    // Next beat: from live registers when starting, snapshot while sending
    always_comb begin
        w_g_len   = w_busy ? r_cfg_len  : r_len;
        w_g_off   = w_busy ? r_cfg_off  : r_offset;
        w_g_seed  = w_busy ? r_cfg_seed : r_seed;
        w_g_ins   = w_busy ? r_cfg_ins  : bus.csr_writedata_i[2];
        w_g_word  = (!w_busy || r_eop) ? 16'd0 : r_word + 16'd1;
        w_last_word = (w_g_len - 16'd1) >> 3;
        w_g_eop   = (w_g_word == w_last_word);
        w_g_empty = w_g_eop ? (3'd0 - w_g_len[2:0]) : 3'd0;
        w_g_data  = '0;
        for (int k = 0; k < 8; k++)
            w_g_data[8*k +: 8] = f_byte({w_g_word, 3'(k)}, w_g_len,
                                        w_g_off, w_g_seed, w_g_ins);
    end

    // Transmit FSM with registered stream outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_cfg_len  <= LEN_RST;
            r_cfg_off  <= '0;
            r_cfg_seed <= '0;
            r_cfg_ins  <= 1'b0;
            r_word     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_empty    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_SEND;
                        r_cfg_len  <= r_len;
                        r_cfg_off  <= r_offset;
                        r_cfg_seed <= r_seed;
                        r_cfg_ins  <= bus.csr_writedata_i[2];
                        r_word     <= '0;
                        r_data     <= w_g_data;
                        r_eop      <= w_g_eop;
                        r_empty    <= w_g_empty;
                        r_valid    <= 1'b1;
                        r_sop      <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_eop && !w_cont) begin
                            r_state <= S_IDLE;
                            r_word  <= '0;
                            r_data  <= '0;
                            r_valid <= 1'b0;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b0;
                            r_empty <= '0;
                        end else begin
                            r_word  <= w_g_word;
                            r_data  <= w_g_data;
                            r_eop   <= w_g_eop;
                            r_empty <= w_g_empty;
                            r_sop   <= r_eop;
                        end
                    end
                end
            endcase
        end
    end

    // CSR register writes and packet counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ins_en <= 1'b0;
            r_len    <= LEN_RST;
            r_offset <= '0;
            r_seed   <= '0;
            r_pktcnt <= '0;
`ifdef PACKET_GEN_CONTINUOUS_EN
            r_cont   <= 1'b0;
`endif
        end else begin
            if (w_wr && bus.csr_address_i == 3'd0) begin
                if (!w_busy) r_ins_en <= bus.csr_writedata_i[2];
`ifdef PACKET_GEN_CONTINUOUS_EN
                r_cont <= bus.csr_writedata_i[3];
`endif
            end
            if (w_wr && bus.csr_address_i == 3'd1 && !w_busy
                && bus.csr_writedata_i != 32'd0
                && bus.csr_writedata_i <= MAX_LEN)
                r_len <= bus.csr_writedata_i[15:0];
            if (w_wr && bus.csr_address_i == 3'd2 && !w_busy)
                r_offset <= bus.csr_writedata_i[15:0];
            if (w_wr && bus.csr_address_i == 3'd3 && !w_busy)
                r_seed <= bus.csr_writedata_i[7:0];
            if (w_wr && bus.csr_address_i == 3'd4)
                r_pktcnt <= '0;
            else if (w_last_xfer)
                r_pktcnt <= r_pktcnt + 32'd1;
        end
    end

    // Read-back mux
    always_comb begin
        w_rdata = '0;
        case (bus.csr_address_i)
            3'd0:    w_rdata = {28'd0, w_cont, r_ins_en, w_busy, 1'b0};
            3'd1:    w_rdata = {16'd0, r_len};
            3'd2:    w_rdata = {16'd0, r_offset};
            3'd3:    w_rdata = {24'd0, r_seed};
            3'd4:    w_rdata = r_pktcnt;
            default: w_rdata = '0;
        endcase
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= bus.csr_read_i;
            r_rdata  <= bus.csr_read_i ? w_rdata : 32'd0;
        end
    end

    assign bus.csr_readdata_o      = r_rdata;
    assign bus.csr_readdatavalid_o = r_rvalid;
    assign bus.csr_waitrequest_o   = 1'b0;
    assign bus.ast_data_o          = r_data;
    assign bus.ast_valid_o         = r_valid;
    assign bus.ast_startofpacket_o = r_sop;
    assign bus.ast_endofpacket_o   = r_eop;
    assign bus.ast_empty_o         = r_empty;
endmodule

// File: tb/tb_packet_gen.sv
// Testbench for packet_gen: vector table, random packets vs byte model.
// Covers the PACKET_GEN_CONTINUOUS_EN build as well as the default one.
module tb_packet_gen;
    logic clk;
    logic rst_n;
    packet_gen_if bus ();

    packet_gen dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    logic [95:0] pat = 96'h21646C726F772C6F6C6C6568;
    logic [63:0] exp_q[$];
    logic [2:0]  exp_empty;

    logic [63:0] act_first;
    logic [63:0] act_last;
    logic [2:0]  act_empty;
    int          act_beats;

    bit cnt_en = 0;
    int eop_cnt = 0;

    always @(negedge clk)
        if (cnt_en && bus.ast_valid_o && bus.ast_ready_i
            && bus.ast_endofpacket_o)
            eop_cnt <= eop_cnt + 1;

    typedef struct {
        int          len;
        int          off;
        int          seed;
        bit          ins;
        int          mode;
        bit          busy_wr;
        logic [63:0] first;
        logic [63:0] last;
        int          empty;
        int          beats;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        bus.csr_address_i   = a;
        bus.csr_writedata_i = d;
        bus.csr_write_i     = 1'b1;
        @(negedge clk);
        bus.csr_write_i     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        bus.csr_address_i = a;
        bus.csr_read_i    = 1'b1;
        @(negedge clk);
        bus.csr_read_i    = 1'b0;
        chk("rdvalid", 128'(bus.csr_readdatavalid_o), 128'd1);
        d = bus.csr_readdata_o;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a,
                            input logic [31:0] e);
        logic [31:0] d;
        csr_read(a, d);
        chk(name, 128'(d), 128'(e));
    endtask

    // Reference: lay out the packet as a byte array, then cut into beats
    task automatic build_model(input int len, input int off,
                               input int seed, input bit ins);
        logic [7:0] b[];
        int nb;
        nb = (len + 7) / 8;
        b  = new[nb * 8];
        foreach (b[i]) b[i] = (i < len) ? 8'(seed + i) : 8'h00;
        if (ins && off + 12 <= len)
            for (int j = 0; j < 12; j++) b[off + j] = pat[j*8 +: 8];
        exp_q.delete();
        for (int w = 0; w < nb; w++) begin
            logic [63:0] d;
            for (int k = 0; k < 8; k++) d[8*k +: 8] = b[8*w + k];
            exp_q.push_back(d);
        end
        exp_empty = 3'((nb * 8 - len) % 8);
    endtask

    task automatic run_pkt(input int len, input int off, input int seed,
                           input bit ins, input int mode,
                           input bit busy_wr);
        int nb;
        int got;
        int cyc;
        bit stall;
        bit r;
        logic [69:0] cur;
        logic [69:0] prev;
        bus.ast_ready_i = 1'b0;
        csr_write(3'd1, 32'(len));
        csr_write(3'd2, 32'(off));
        csr_write(3'd3, 32'(seed));
        csr_write(3'd0, 32'h1 | (32'(ins) << 2));
        if (busy_wr) csr_write(3'd1, 32'd5);
        build_model(len, off, seed, ins);
        nb = exp_q.size();
        got = 0;
        cyc = 0;
        stall = 0;
        prev = '0;
        while (got < nb) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.ast_ready_i = r;
            cur = {bus.ast_data_o, bus.ast_startofpacket_o,
                   bus.ast_endofpacket_o, bus.ast_empty_o,
                   bus.ast_valid_o};
            if (stall) chk("hold", 128'(cur), 128'(prev));
            chk("valid", 128'(bus.ast_valid_o), 128'd1);
            if (bus.ast_valid_o && r) begin
                chk("beat",
                    {bus.ast_data_o, bus.ast_startofpacket_o,
                     bus.ast_endofpacket_o, bus.ast_empty_o},
                    {exp_q[got], got == 0, got == nb - 1,
                     (got == nb - 1) ? exp_empty : 3'd0});
                if (got == 0) act_first = bus.ast_data_o;
                act_last  = bus.ast_data_o;
                act_empty = bus.ast_empty_o;
                got++;
            end
            stall = bus.ast_valid_o && !r;
            prev  = cur;
            @(negedge clk);
            cyc++;
            if (cyc > 4 * nb + 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: got %0d beats, need %0d", got, nb);
                break;
            end
        end
        bus.ast_ready_i = 1'b0;
        act_beats = got;
        chk("idle_after", 128'(bus.ast_valid_o), 128'd0);
        exp_cnt++;
        read_chk("pktcnt", 3'd4, 32'(exp_cnt));
        read_chk("ctrl", 3'd0, 32'(ins) << 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        tbl[0] = '{12, 0, 0, 1, 0, 0, 64'h6F772C6F6C6C6568,
                   64'h0000000021646C72, 4, 2};
        tbl[1] = '{17, 0, 'hF0, 0, 0, 0, 64'hF7F6F5F4F3F2F1F0,
                   64'h0, 7, 3};
        tbl[2] = '{64, 0, 0, 0, 1, 1, 64'h0706050403020100,
                   64'h3F3E3D3C3B3A3938, 0, 8};
        tbl[3] = '{16, 4, 0, 1, 0, 0, 64'h6C6C656803020100,
                   64'h21646C726F772C6F, 0, 2};
        tbl[4] = '{64, 52, 0, 1, 0, 0, 64'h0706050403020100,
                   64'h21646C726F772C6F, 0, 8};
        tbl[5] = '{64, 53, 0, 1, 2, 0, 64'h0706050403020100,
                   64'h3F3E3D3C3B3A3938, 0, 8};
        tbl[6] = '{8, 0, 'h10, 0, 0, 0, 64'h1716151413121110,
                   64'h1716151413121110, 0, 1};
        tbl[7] = '{1, 0, 'hAA, 1, 0, 0, 64'hAA, 64'hAA, 7, 1};
        tbl[8] = '{2048, 2036, 0, 1, 0, 0, 64'h0706050403020100,
                   64'h21646C726F772C6F, 0, 256};

        rst_n = 1'b0;
        bus.csr_address_i   = '0;
        bus.csr_write_i     = 1'b0;
        bus.csr_writedata_i = '0;
        bus.csr_read_i      = 1'b0;
        bus.ast_ready_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs",
            {bus.ast_data_o, bus.ast_valid_o, bus.ast_startofpacket_o,
             bus.ast_endofpacket_o, bus.ast_empty_o,
             bus.csr_readdatavalid_o, bus.csr_readdata_o},
            128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("rst_len", 3'd1, 32'd64);
        read_chk("rst_cnt", 3'd4, 32'd0);
        read_chk("rst_ctrl", 3'd0, 32'd0);
        read_chk("rst_off", 3'd2, 32'd0);
        read_chk("rst_seed", 3'd3, 32'd0);
        chk("waitreq", 128'(bus.csr_waitrequest_o), 128'd0);

        foreach (tbl[i]) begin
            run_pkt(tbl[i].len, tbl[i].off, tbl[i].seed, tbl[i].ins,
                    tbl[i].mode, tbl[i].busy_wr);
            chk($sformatf("t%0d_first", i), 128'(act_first),
                128'(tbl[i].first));
            chk($sformatf("t%0d_last", i), 128'(act_last),
                128'(tbl[i].last));
            chk($sformatf("t%0d_empty", i), 128'(act_empty),
                128'(tbl[i].empty));
            chk($sformatf("t%0d_beats", i), 128'(act_beats),
                128'(tbl[i].beats));
            if (tbl[i].busy_wr)
                read_chk("busy_len", 3'd1, 32'(tbl[i].len));
        end

        csr_write(3'd1, 32'd100);
        csr_write(3'd1, 32'd0);
        csr_write(3'd1, 32'd2049);
        read_chk("len_illegal", 3'd1, 32'd100);
        csr_write(3'd5, 32'hFFFF);
        read_chk("unmapped5", 3'd5, 32'd0);
        read_chk("unmapped7", 3'd7, 32'd0);

        for (int i = 0; i < 15; i++) begin
            int len;
            int off;
            len = $urandom_range(1, 120);
            off = $urandom_range(0, len + 4);
            run_pkt(len, off, $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 2, 0);
        end

        csr_write(3'd4, 32'd77);
        exp_cnt = 0;
        read_chk("cnt_clear", 3'd4, 32'd0);

`ifdef PACKET_GEN_CONTINUOUS_EN
        csr_write(3'd1, 32'd8);
        csr_write(3'd2, 32'd0);
        csr_write(3'd3, 32'h33);
        bus.ast_ready_i = 1'b1;
        eop_cnt = 0;
        cnt_en  = 1;
        csr_write(3'd0, 32'h9);
        for (int i = 0; i < 6; i++) begin
            chk("cont_beat",
                {bus.ast_valid_o, bus.ast_startofpacket_o,
                 bus.ast_endofpacket_o, bus.ast_data_o},
                {3'b111, 64'h3A39383736353433});
            @(negedge clk);
        end
        csr_write(3'd0, 32'h0);
        for (int i = 0; i < 10 && bus.ast_valid_o; i++) @(negedge clk);
        chk("cont_stop", 128'(bus.ast_valid_o), 128'd0);
        cnt_en = 0;
        bus.ast_ready_i = 1'b0;
        chk("cont_many", 128'(eop_cnt >= 7), 128'd1);
        read_chk("cont_cnt", 3'd4, 32'(eop_cnt));
        exp_cnt = eop_cnt;
`else
        csr_write(3'd0, 32'h8);
        read_chk("cont_ro", 3'd0, 32'd0);
        csr_write(3'd1, 32'd8);
        csr_write(3'd2, 32'd0);
        csr_write(3'd3, 32'h33);
        bus.ast_ready_i = 1'b1;
        eop_cnt = 0;
        cnt_en  = 1;
        csr_write(3'd0, 32'h9);
        repeat (6) @(negedge clk);
        cnt_en = 0;
        bus.ast_ready_i = 1'b0;
        chk("single_pkt", 128'(eop_cnt), 128'd1);
        exp_cnt++;
        read_chk("single_cnt", 3'd4, 32'(exp_cnt));
        read_chk("single_ctrl", 3'd0, 32'd0);
`endif

        csr_write(3'd1, 32'd40);
        csr_write(3'd0, 32'h1);
        @(negedge clk);
        chk("pre_rst_valid", 128'(bus.ast_valid_o), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst",
            {bus.ast_valid_o, bus.ast_startofpacket_o, bus.ast_data_o},
            128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("rst2_len", 3'd1, 32'd64);
        read_chk("rst2_cnt", 3'd4, 32'd0);
        read_chk("rst2_ctrl", 3'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
